// File: rtl/backup_pkg.sv
// Shared types and constants for the backup/restore controller.
package backup_pkg;
  localparam int N_CU_REGS  = 3;
  localparam int N_DP_REGS  = 50;
  localparam int N_REGS_DEF = N_CU_REGS + N_DP_REGS;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    IDLE, B_SCAN, B_WRITE, B_ACK, OFF, R_READ, R_LOAD, R_DONE
  } state_t;
endpackage

// File: rtl/backup_nvm_if.sv
// NVM word-access bus between the backup controller (master) and the NVM (slave).
interface backup_nvm_if #(parameter int AW = 6);
  import backup_pkg::*;
  logic              req;
  logic              we;
  logic [AW-1:0]     addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/nvm_if_seq.sv
// NVM handshake: request is held while the FSM sits in a transfer state;
// ack is only honoured during a request, and read data is latched on ack.
module nvm_if_seq import backup_pkg::*; #(
  parameter int AW = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              xfer_done,
  output logic [WORD_W-1:0] rdata_q,
  backup_nvm_if.master      nvm
);
  assign nvm.req   = wr_en | rd_en;
  assign nvm.we    = wr_en;
  assign nvm.addr  = nvm.req ? addr : '0;
  assign nvm.wdata = wr_en ? wdata : '0;
  assign xfer_done = nvm.req & nvm.ack;

  always_ff @(posedge Clk) begin
    if (Rst)                 rdata_q <= '0;
    else if (rd_en & nvm.ack) rdata_q <= nvm.rdata;
  end
endmodule

// File: rtl/backup_ctrl.sv
// Backup/restore sequencer: walks the registers into NVM on pwr_fail and back on pwr_good.
// Optional BACKUP_SKIP_CLEAN_EN: back up only dirty registers, restore only from a valid image.
module backup_ctrl import backup_pkg::*; #(
  parameter int N_REGS       = N_REGS_DEF,
  parameter int NVM_ADDR_LEN = 6
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       pwr_fail,
  input  logic                       pwr_good,
  input  logic [2*N_REGS-1:0]        dirty_vals,
  input  logic [WORD_W*N_REGS-1:0]   backup_Vouts,
  output logic [N_REGS-1:0]          backup_ens,
  output logic [N_REGS-1:0]          backup_acks,
  output logic [N_REGS-1:0]          restore_ens,
  output logic [WORD_W*N_REGS-1:0]   restore_Vins,
  backup_nvm_if.master               nvm,
  output logic                       stand_by,
  output logic                       Pwr_off,
  output logic                       busy,
  output logic                       done
);
  state_t                  state, state_n;
  logic [NVM_ADDR_LEN-1:0] idx, idx_n;
  logic                    image_valid, done_off, xfer_done, sel, restore_ok, last;
  logic [WORD_W-1:0]       restore_data, cur_vout;
  logic [1:0]              cur_dirty;

  always_comb begin
    cur_vout  = '0;
    cur_dirty = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == NVM_ADDR_LEN'(i)) begin
        cur_vout  = backup_Vouts[WORD_W*i +: WORD_W];
        cur_dirty = dirty_vals[2*i +: 2];
      end
    end
  end

  assign last = (idx == NVM_ADDR_LEN'(N_REGS-1));

`ifdef BACKUP_SKIP_CLEAN_EN
  // dirty since last backup and written since reset
  assign sel        = &cur_dirty;
  assign restore_ok = image_valid;
`else
  logic unused_cfg;
  assign sel        = 1'b1;
  assign restore_ok = 1'b1;
  assign unused_cfg = ^{cur_dirty, image_valid};
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE:    if (pwr_fail) begin
                 state_n = B_SCAN; idx_n = '0;
               end else if (pwr_good && restore_ok) begin
                 state_n = R_READ; idx_n = '0;
               end
      B_SCAN:  if (sel)       state_n = B_WRITE;
               else if (last) state_n = OFF;
               else           idx_n   = idx + NVM_ADDR_LEN'(1);
      B_WRITE: if (xfer_done) state_n = B_ACK;
      B_ACK:   if (last) state_n = OFF;
               else begin state_n = B_SCAN; idx_n = idx + NVM_ADDR_LEN'(1); end
      OFF:     if (pwr_good) begin state_n = R_READ; idx_n = '0; end
      R_READ:  if (xfer_done) state_n = R_LOAD;
      R_LOAD:  if (last) state_n = R_DONE;
               else begin state_n = R_READ; idx_n = idx + NVM_ADDR_LEN'(1); end
      R_DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      idx         <= '0;
      image_valid <= 1'b0;
      done_off    <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      done_off <= (state_n == OFF) && (state != OFF);
      if (state_n == OFF) image_valid <= 1'b1;
    end
  end

  nvm_if_seq #(.AW(NVM_ADDR_LEN)) u_seq (
    .Clk       (Clk),
    .Rst       (Rst),
    .wr_en     (state == B_WRITE),
    .rd_en     (state == R_READ),
    .addr      (idx),
    .wdata     (cur_vout),
    .xfer_done (xfer_done),
    .rdata_q   (restore_data),
    .nvm       (nvm)
  );

  for (genvar i = 0; i < N_REGS; i++) begin : g_lane
    logic hit;
    assign hit                               = (idx == NVM_ADDR_LEN'(i));
    assign backup_ens[i]                     = hit && (state == B_WRITE);
    assign backup_acks[i]                    = hit && (state == B_ACK);
    assign restore_ens[i]                    = hit && (state == R_LOAD);
    assign restore_Vins[WORD_W*i +: WORD_W]  = restore_data;
  end

  assign stand_by = (state != IDLE);
  assign busy     = (state != IDLE);
  assign Pwr_off  = (state == OFF);
  assign done     = done_off | (state == R_DONE);
endmodule

// File: tb/tb_backup_ctrl.sv
// Directed bench for backup_ctrl with N_REGS=4 and a 2-cycle-latency NVM model.
module tb_backup_ctrl;
  import backup_pkg::*;
  localparam int NR = 4;
  localparam int AW = 3;
`ifdef BACKUP_SKIP_CLEAN_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              Clk = 1'b0, Rst = 1'b1, pwr_fail = 1'b0, pwr_good = 1'b0;
  logic [2*NR-1:0]   dirty_vals = '0;
  logic [32*NR-1:0]  backup_Vouts = '0;
  logic [NR-1:0]     backup_ens, backup_acks, restore_ens;
  logic [32*NR-1:0]  restore_Vins;
  logic              stand_by, Pwr_off, busy, done;
  int                checks = 0, errors = 0;

  backup_nvm_if #(.AW(AW)) nvm();

  backup_ctrl #(.N_REGS(NR), .NVM_ADDR_LEN(AW)) dut (
    .Clk(Clk), .Rst(Rst), .pwr_fail(pwr_fail), .pwr_good(pwr_good),
    .dirty_vals(dirty_vals), .backup_Vouts(backup_Vouts),
    .backup_ens(backup_ens), .backup_acks(backup_acks), .restore_ens(restore_ens),
    .restore_Vins(restore_Vins), .nvm(nvm), .stand_by(stand_by), .Pwr_off(Pwr_off),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // NVM model: ack arrives in the second cycle of a request; reads return A5A5_0000+addr
  int              req_cycles = 0;
  logic [AW-1:0]   wr_addr_q [$];
  logic [31:0]     wr_data_q [$];
  assign nvm.rdata = 32'hA5A5_0000 + 32'(nvm.addr);
  always @(posedge Clk) begin
    if (Rst) nvm.ack <= 1'b0;
    else if (nvm.ack) begin
      nvm.ack <= 1'b0;
      if (nvm.req && nvm.we) begin
        wr_addr_q.push_back(nvm.addr);
        wr_data_q.push_back(nvm.wdata);
      end
    end else nvm.ack <= nvm.req;
    if (nvm.req) req_cycles <= req_cycles + 1;
  end

  task automatic tick();
    @(posedge Clk); @(negedge Clk);
  endtask

  function automatic bit selected(input logic [2*NR-1:0] d, input int i);
    return !SKIP || (d[2*i +: 2] == 2'b11);
  endfunction

  // cycles from the first edge seeing pwr_fail up to and including the edge entering OFF
  function automatic int exp_backup_cycles(input logic [2*NR-1:0] d);
    int c = 1;
    for (int i = 0; i < NR; i++) c += selected(d, i) ? 4 : 1;
    return c;
  endfunction

  task automatic test_reset();
    Rst = 1'b1; pwr_fail = 1'b0; pwr_good = 1'b0;
    repeat (2) tick();
    Rst = 1'b0;
    tick();
    checks++; if ({busy, stand_by} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", {busy, stand_by}); end
    checks++; if (nvm.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", nvm.req); end
    checks++; if ({backup_ens, backup_acks, restore_ens} !== '0) begin errors++; $display("FAIL reset_onehots got %h exp 0", {backup_ens, backup_acks, restore_ens}); end
    checks++; if (restore_Vins !== '0) begin errors++; $display("FAIL reset_vins got %h exp 0", restore_Vins); end
    checks++; if ({Pwr_off, done} !== 2'b00) begin errors++; $display("FAIL reset_off_done got %b exp 00", {Pwr_off, done}); end
  endtask

  task automatic test_backup();
    int n = 0, dn = 0, viol = 0, w0;
    int acks [$];
    int exp_idx [$];
    dirty_vals = 8'b00_11_00_11;
    for (int i = 0; i < NR; i++) if (selected(dirty_vals, i)) exp_idx.push_back(i);
    w0 = wr_addr_q.size();
    pwr_fail = 1'b1;
    while (n < 100) begin
      @(posedge Clk); n++; @(negedge Clk);
      if (done) dn++;
      if ($countones(backup_ens) > 1 || $countones(backup_acks) > 1) viol++;
      if (nvm.req && nvm.we && backup_ens != (NR'(1) << nvm.addr)) viol++;
      for (int i = 0; i < NR; i++) if (backup_acks[i]) acks.push_back(i);
      if (Pwr_off) break;
    end
    pwr_fail = 1'b0;
    repeat (2) begin tick(); if (done) dn++; end
    checks++; if (n !== exp_backup_cycles(dirty_vals)) begin errors++; $display("FAIL bk_cycles got %0d exp %0d", n, exp_backup_cycles(dirty_vals)); end
    checks++; if (Pwr_off !== 1'b1) begin errors++; $display("FAIL bk_pwr_off got %b exp 1", Pwr_off); end
    checks++; if (wr_addr_q.size() - w0 !== exp_idx.size()) begin errors++; $display("FAIL bk_nwrites got %0d exp %0d", wr_addr_q.size() - w0, exp_idx.size()); end
    foreach (exp_idx[k]) begin
      checks++; if (32'(wr_addr_q[w0+k]) !== 32'(exp_idx[k])) begin errors++; $display("FAIL bk_addr%0d got %0d exp %0d", k, wr_addr_q[w0+k], exp_idx[k]); end
      checks++; if (wr_data_q[w0+k] !== 32'hC0DE_0000 + 32'(exp_idx[k])) begin errors++; $display("FAIL bk_data%0d got %h exp %h", k, wr_data_q[w0+k], 32'hC0DE_0000 + 32'(exp_idx[k])); end
    end
    checks++; if (acks.size() !== exp_idx.size()) begin errors++; $display("FAIL bk_nacks got %0d exp %0d", acks.size(), exp_idx.size()); end
    foreach (exp_idx[k]) begin
      checks++; if (acks[k] !== exp_idx[k]) begin errors++; $display("FAIL bk_ack%0d got %0d exp %0d", k, acks[k], exp_idx[k]); end
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL bk_done got %0d exp 1", dn); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL bk_onehot got %0d exp 0", viol); end
  endtask

  task automatic test_restore();
    int n = 0, pulses = 0, bad = 0, dn = 0;
    logic [32*NR-1:0] exp_v;
    pwr_good = 1'b1;
    while (n < 100) begin
      @(posedge Clk); n++; @(negedge Clk);
      if (!Pwr_off) pwr_good = 1'b0;
      if (restore_ens != '0) begin
        exp_v = {NR{32'hA5A5_0000 + 32'(pulses)}};
        if (restore_ens !== (NR'(1) << pulses) || restore_Vins !== exp_v) bad++;
        pulses++;
        if (pulses == 2) pwr_fail = 1'b1;
      end
      if (done) begin dn++; break; end
    end
    checks++; if (pulses !== NR) begin errors++; $display("FAIL rs_pulses got %0d exp %0d", pulses, NR); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rs_data got %0d bad exp 0", bad); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL rs_done got %0d exp 1", dn); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_idle got %b exp 0", busy); end
    tick();
    checks++; if ({busy, Pwr_off} !== 2'b10) begin errors++; $display("FAIL rs_late_fail got %b exp 10", {busy, Pwr_off}); end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    while (n < 50 && !(nvm.req && nvm.we && !nvm.ack)) begin tick(); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL rw_reach got %0d exp <50", n); end
    checks++; if (dut.image_valid !== 1'b1) begin errors++; $display("FAIL rw_ivalid_pre got %b exp 1", dut.image_valid); end
    Rst = 1'b1;
    tick();
    checks++; if ({busy, stand_by, Pwr_off, done} !== 4'b0) begin errors++; $display("FAIL rw_status got %b exp 0000", {busy, stand_by, Pwr_off, done}); end
    checks++; if ({nvm.req, nvm.we, backup_ens} !== '0) begin errors++; $display("FAIL rw_bus got %h exp 0", {nvm.req, nvm.we, backup_ens}); end
    checks++; if (dut.image_valid !== 1'b0) begin errors++; $display("FAIL rw_ivalid got %b exp 0", dut.image_valid); end
    Rst = 1'b0; pwr_fail = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_stay_idle got %b exp 0", busy); end
  endtask

  task automatic test_restore_gate();
    logic exp_go = !SKIP;
    pwr_good = 1'b1;
    tick();
    checks++; if (busy !== exp_go) begin errors++; $display("FAIL gate_busy got %b exp %b", busy, exp_go); end
    checks++; if ({nvm.req, nvm.we} !== {exp_go, 1'b0}) begin errors++; $display("FAIL gate_req got %b exp %b", {nvm.req, nvm.we}, {exp_go, 1'b0}); end
    pwr_good = 1'b0; Rst = 1'b1;
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_both_high();
    pwr_fail = 1'b1; pwr_good = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL both_busy got %b exp 1", busy); end
    tick();
    checks++; if ({nvm.req, nvm.we} !== 2'b11) begin errors++; $display("FAIL both_write got %b exp 11", {nvm.req, nvm.we}); end
    pwr_fail = 1'b0; pwr_good = 1'b0; Rst = 1'b1;
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_no_dirty();
    int n = 0, r0, exp_req = 0;
    dirty_vals = '0;
    for (int i = 0; i < NR; i++) if (selected(dirty_vals, i)) exp_req += 2;
    r0 = req_cycles;
    pwr_fail = 1'b1;
    while (n < 100) begin
      @(posedge Clk); n++; @(negedge Clk);
      if (Pwr_off) break;
    end
    pwr_fail = 1'b0;
    checks++; if (n !== exp_backup_cycles(dirty_vals)) begin errors++; $display("FAIL nd_cycles got %0d exp %0d", n, exp_backup_cycles(dirty_vals)); end
    checks++; if (req_cycles - r0 !== exp_req) begin errors++; $display("FAIL nd_reqs got %0d exp %0d", req_cycles - r0, exp_req); end
    checks++; if (Pwr_off !== 1'b1) begin errors++; $display("FAIL nd_pwr_off got %b exp 1", Pwr_off); end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) backup_Vouts[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
    test_reset();
    test_backup();
    test_restore();
    test_reset_mid_write();
    test_restore_gate();
    test_both_high();
    test_no_dirty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
